// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: widths, FSM states and the byte
// substitution used by the expansion datapath.
package aes_pkg;

   localparam int KEY_W    = 256;
   localparam int RK_W     = 128;
   localparam int NUM_RK   = 15;
   localparam int MAX_RCON = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_DONE
   } state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = '0;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by
   // the affine transform, so no 256-entry table has to be maintained.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/key_expansion.sv
// One AES-256 expansion step: eight previous words in, eight new words out.
// Outputs follow the datapath while enabled and hold their last value otherwise.
module key_expansion
   import aes_pkg::*;
(
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iEn,
   input  logic [0:KEY_W-1]  iKey,
   input  logic [3:0]        cnt_rcon,
   output logic [0:RK_W-1]   oMSB_Key,
   output logic [0:RK_W-1]   oLSB_Key
);

   logic [31:0]      w [8];
   logic [31:0]      n0, n1, n2, n3, n4, n5, n6, n7;
   logic [7:0]       rc;
   logic [0:RK_W-1]  lsb_c, msb_c;
   logic [0:RK_W-1]  lsb_q, msb_q;

   always_comb begin
      for (int i = 0; i < 8; i++) w[i] = iKey[32*i +: 32];
      rc = 8'h01 << (cnt_rcon - 4'd1);
      n0 = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h000000};
      n1 = w[1] ^ n0;
      n2 = w[2] ^ n1;
      n3 = w[3] ^ n2;
      n4 = w[4] ^ sub_word(n3);
      n5 = w[5] ^ n4;
      n6 = w[6] ^ n5;
      n7 = w[7] ^ n6;
      lsb_c = {n0, n1, n2, n3};
      msb_c = {n4, n5, n6, n7};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         lsb_q <= '0;
         msb_q <= '0;
      end else if (iEn) begin
         lsb_q <= lsb_c;
         msb_q <= msb_c;
      end
   end

   assign oLSB_Key = iEn ? lsb_c : lsb_q;
   assign oMSB_Key = iEn ? msb_c : msb_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-256 key schedule controller: walks key_expansion through seven rounds
// and keeps all fifteen round keys in registers for indexed read-back.
module key_schedule_ctrl
   import aes_pkg::*;
#(
   parameter int EXP_WAIT = 2
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iStart,
   input  logic [0:KEY_W-1]  iKey,
   input  logic [3:0]        iRd_idx,
   output logic [0:RK_W-1]   oRd_key,
   output logic              oBusy,
   output logic              oDone,
   output logic              oKey_valid
);

   localparam logic [1:0] LAST_WAIT = 2'(EXP_WAIT - 1);
   localparam logic [3:0] LAST_RCON = 4'(MAX_RCON);
   localparam logic [3:0] LAST_IDX  = 4'(NUM_RK - 1);

   state_t           state;
   logic [0:KEY_W-1] work_key;
   logic [3:0]       rcon;
   logic [1:0]       wait_cnt;
   logic [0:RK_W-1]  rk [NUM_RK];
   logic [0:RK_W-1]  exp_msb, exp_lsb;
   logic             exp_en;
   logic [3:0]       lo_idx, hi_idx;

   assign exp_en = (state == ST_EXPAND);
   assign lo_idx = {rcon[2:0], 1'b0};
   assign hi_idx = {rcon[2:0], 1'b1};

   key_expansion u_key_expansion (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iEn      (exp_en),
      .iKey     (work_key),
      .cnt_rcon (rcon),
      .oMSB_Key (exp_msb),
      .oLSB_Key (exp_lsb)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state      <= ST_IDLE;
         work_key   <= '0;
         rcon       <= '0;
         wait_cnt   <= '0;
         oRd_key    <= '0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oKey_valid <= 1'b0;
         // NOTE: the store is plain flops, so it can and does take the async
         // reset; a RAM-mapped array could not be cleared this way.
         for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
      end else begin
         if (oKey_valid && iRd_idx <= LAST_IDX) oRd_key <= rk[iRd_idx];
         else                                   oRd_key <= '0;

         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  work_key   <= iKey;
                  rk[0]      <= iKey[0:RK_W-1];
                  rk[1]      <= iKey[RK_W:KEY_W-1];
                  rcon       <= 4'd1;
                  wait_cnt   <= '0;
                  oKey_valid <= 1'b0;
                  oBusy      <= 1'b1;
                  state      <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               if (wait_cnt == LAST_WAIT) begin
                  work_key   <= {exp_lsb, exp_msb};
                  rk[lo_idx] <= exp_lsb;
                  wait_cnt   <= '0;
                  // Round 7 only needs its first half: rk[14] is the last key.
                  if (rcon == LAST_RCON) begin
                     oDone <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     rk[hi_idx] <= exp_msb;
                     rcon       <= rcon + 4'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ST_DONE: begin
               oDone      <= 1'b0;
               oBusy      <= 1'b0;
               oKey_valid <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: FIPS-197 vectors plus random keys against a
// word-recurrence model with an independently generated S-box.
module tb_key_schedule_ctrl;

   logic         iClk = 1'b0;
   logic         iRst_n = 1'b0;
   logic         iStart = 1'b0;
   logic [0:255] iKey = '0;
   logic [3:0]   iRd_idx = '0;
   logic [0:127] oRd_key;
   logic         oBusy, oDone, oKey_valid;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] NIST_KEY =
      256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

   logic [7:0]   sbox_t [256];
   logic [127:0] model_rk [15];

   always #5 iClk = ~iClk;

   key_schedule_ctrl #(.EXP_WAIT(2)) dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iStart     (iStart),
      .iKey       (iKey),
      .iRd_idx    (iRd_idx),
      .oRd_key    (oRd_key),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oKey_valid (oKey_valid)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // S-box from walking generator 3 and its inverse around GF(2^8)*.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [31:0] sw(input logic [31:0] v);
      return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
   endfunction

   task automatic build_model(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = {rc[6:0], 1'b0};
         end else if (i % 8 == 4) begin
            t = sw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   task automatic start_run(input logic [255:0] key);
      @(negedge iClk);
      iKey   = key;
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
   endtask

   // Observes 20 edges after the accept; optionally re-pulses iStart mid-run.
   task automatic run_window(input string tag, input int restart_at, input logic [255:0] alt_key);
      int first  = -1;
      int pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k == restart_at) begin
            iStart = 1'b1;
            iKey   = alt_key;
         end else begin
            iStart = 1'b0;
         end
         @(negedge iClk);
         if (oDone) begin
            pulses++;
            if (first < 0) first = k;
         end
         if (k == 1) begin
            check({tag, "_busy_k1"}, 128'(oBusy), 128'd1);
            check({tag, "_valid_k1"}, 128'(oKey_valid), 128'd0);
         end
         if (k == 3) check({tag, "_rd_while_invalid"}, oRd_key, 128'd0);
         if (k == 15) begin
            check({tag, "_valid_k15"}, 128'(oKey_valid), 128'd1);
            check({tag, "_busy_k15"}, 128'(oBusy), 128'd0);
         end
      end
      check({tag, "_done_edge"}, 128'(first), 128'd14);
      check({tag, "_done_pulses"}, 128'(pulses), 128'd1);
   endtask

   task automatic read_rk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
      @(negedge iClk);
      iRd_idx = idx;
      @(negedge iClk);
      check(tag, oRd_key, exp);
   endtask

   task automatic check_all(input string tag);
      for (int j = 0; j < 15; j++) read_rk($sformatf("%s_rk%0d", tag, j), 4'(j), model_rk[j]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] rkey;
      build_sbox();

      repeat (3) @(negedge iClk);
      check("rst_rd_key", oRd_key, 128'd0);
      check("rst_busy", 128'(oBusy), 128'd0);
      check("rst_done", 128'(oDone), 128'd0);
      check("rst_valid", 128'(oKey_valid), 128'd0);
      iRst_n = 1'b1;
      read_rk("idle_invalid_rd", 4'd2, 128'd0);

      // FIPS-197 AES-256 vector
      build_model(NIST_KEY);
      start_run(NIST_KEY);
      run_window("nist", 0, '0);
      read_rk("nist_rk0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
      read_rk("nist_rk1", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
      read_rk("nist_rk2", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
      read_rk("nist_rk3", 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
      read_rk("nist_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
      read_rk("idx15_zero", 4'd15, 128'd0);
      check_all("nist_model");

      // restart from a valid schedule, with a stray iStart mid-expansion
      start_run(NIST_KEY);
      run_window("repulse", 5, {$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom(), $urandom()});
      check_all("repulse");

      // reset in the middle of an expansion
      start_run(NIST_KEY);
      repeat (6) @(negedge iClk);
      iRst_n = 1'b0;
      #1;
      check("midrst_rd_key", oRd_key, 128'd0);
      check("midrst_busy", 128'(oBusy), 128'd0);
      check("midrst_done", 128'(oDone), 128'd0);
      check("midrst_valid", 128'(oKey_valid), 128'd0);
      @(negedge iClk);
      iRst_n = 1'b1;
      read_rk("midrst_rd_after", 4'd14, 128'd0);
      start_run(NIST_KEY);
      run_window("after_rst", 0, '0);
      check_all("after_rst");

      // back-to-back: all-zero key then the NIST key
      build_model('0);
      start_run('0);
      run_window("zero", 0, '0);
      check_all("zero");
      check("zero_valid_before_second", 128'(oKey_valid), 128'd1);
      start_run(NIST_KEY);
      check("second_accept_drops_valid", 128'(oKey_valid), 128'd0);
      run_window("second", 0, '0);
      read_rk("second_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

      // random keys
      for (int r = 0; r < 4; r++) begin
         rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
         build_model(rkey);
         start_run(rkey);
         run_window($sformatf("rand%0d", r), 0, '0);
         check_all($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
